// File: rtl/fft_b4_pkg.sv
// ============================================================================
// Module   : fft_b4_pkg
// Purpose  : Shared types and helper functions for the radix-4 FFT sequencer:
//            FSM state encoding, twiddle-address rule, base-4 digit reversal,
//            and pipeline-latency arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_b4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_STAGES    = 3;
    localparam int DEF_STAGE_LAT = 4;
    localparam int DEF_PIPE_LAT  = DEF_STAGES * DEF_STAGE_LAT;

    // Enabled cycles from a sample entering stage 0 to leaving the last stage.
    function automatic int unsigned pipe_lat_f(input int unsigned stages,
                                               input int unsigned stage_lat);
        return stages * stage_lat;
    endfunction

    // Twiddle address for stage s given its sample counter c:
    // (p * m * 4^s) mod N with p = c[1:0], m = (c >> 2) mod (N / 4^(s+1)).
    // p is at most 3, so the product is a shift-and-add; the last stage's
    // modulus is 1, which forces its address to 0.
    function automatic int unsigned tw_addr_f(input int unsigned c,
                                              input int unsigned s,
                                              input int unsigned stages);
        int unsigned aw;
        int unsigned p;
        int unsigned m;
        int unsigned prod;
        aw   = 2 * stages;
        p    = c & 32'd3;
        m    = (c >> 2) & ((32'd1 << (aw - 2 - 2 * s)) - 32'd1);
        prod = (p[0] ? m : 32'd0) + (p[1] ? (m << 1) : 32'd0);
        return (prod << (2 * s)) & ((32'd1 << aw) - 32'd1);
    endfunction

    // Reverse the order of the 2-bit digits of x (digits = number of digits).
    function automatic int unsigned digit_rev4(input int unsigned x,
                                               input int digits);
        int unsigned r;
        r = 32'd0;
        for (int i = 0; i < digits; i++) begin
            r = r | (((x >> (2 * i)) & 32'd3) << (2 * (digits - 1 - i)));
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_b4_seq_ctrl_tw_gen.sv
// ============================================================================
// Module   : fft_b4_tw_gen
// Purpose  : Per-stage twiddle address generator. Tracks the index of the
//            sample entering stage S and presents the matching registered
//            twiddle ROM address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_b4_tw_gen
    import fft_b4_pkg::*;
#(
    parameter int STAGES    = DEF_STAGES,
    parameter int STAGE_LAT = DEF_STAGE_LAT,
    parameter int AW        = 2 * STAGES,
    parameter int S         = 0,
    parameter int FW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [FW-1:0] fill_cnt,
    output logic [AW-1:0] tw_addr
);

    logic          w_active;
    logic [AW-1:0] c_q;
    logic [AW-1:0] c_d;
    logic [AW-1:0] tw_q;
    logic [AW-1:0] tw_d;

    // Stage 0 sees real samples from the first enabled cycle; later stages
    // wait until the pipeline has filled up to their input.
    generate
        if (S == 0) begin : g_first
            assign w_active = 1'b1;
        end else begin : g_later
            assign w_active = (fill_cnt >= FW'(S * STAGE_LAT));
        end
    endgenerate

    // Next sample index and the address that goes with it, so the registered
    // address always matches the registered counter.
    always_comb begin
        c_d = c_q;
        if (clr) begin
            c_d = '0;
        end else if (en && w_active) begin
            c_d = c_q + 1'b1;
        end
        tw_d = AW'(tw_addr_f(32'(c_d), S, STAGES));
    end

    // Counter and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q  <= '0;
            tw_q <= '0;
        end else begin
            c_q  <= c_d;
            tw_q <= tw_d;
        end
    end

    assign tw_addr = tw_q;

endmodule

`default_nettype wire

// File: rtl/fft_b4_seq_ctrl.sv
// ============================================================================
// Module   : fft_b4_seq_ctrl
// Purpose  : Sequencer for a serial radix-4 pipelined FFT. Loads one frame
//            over valid/ready, drives the common stage enable, generates
//            per-stage twiddle addresses, flushes the pipeline and marks the
//            valid output samples.
// Options  : FFT_SEQ_DIGITREV_EN - out_index is the base-4 digit-reversed
//            output count (natural frequency bin) instead of the raw count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_b4_seq_ctrl
    import fft_b4_pkg::*;
#(
    parameter int STAGES    = DEF_STAGES,
    parameter int STAGE_LAT = DEF_STAGE_LAT,
    parameter int AW        = 2 * STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 stage_en,
    output logic                 data_sel,
    output logic [STAGES*AW-1:0] tw_addr,
    output logic                 out_valid,
    output logic [AW-1:0]        out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int N        = 1 << AW;
    localparam int PIPE_LAT = int'(pipe_lat_f(STAGES, STAGE_LAT));
    localparam int FW       = $clog2(PIPE_LAT + 1);

    localparam logic [FW-1:0] FILL_MAX = FW'(PIPE_LAT);
    localparam logic [AW-1:0] IN_LAST  = AW'(N - 1);
    localparam logic [AW:0]   OUT_N    = (AW + 1)'(N);
    localparam logic [AW:0]   OUT_LAST = (AW + 1)'(N - 1);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] in_cnt_q;
    logic [AW-1:0] in_cnt_d;
    logic [FW-1:0] fill_cnt_q;
    logic [FW-1:0] fill_cnt_d;
    logic [AW:0]   out_cnt_q;
    logic [AW:0]   out_cnt_d;
    logic          w_clr;
    logic          w_out_ok;
    logic          w_out_end;

    // Output qualification from registers only, so the FSM can use the
    // end-of-frame condition without a loop through stage_en.
    assign w_out_ok  = (fill_cnt_q == FILL_MAX) && (out_cnt_q < OUT_N);
    assign w_out_end = (fill_cnt_q == FILL_MAX) && (out_cnt_q == OUT_LAST);

    // FSM next state and state-decoded handshake / enable outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        data_sel = 1'b0;
        stage_en = 1'b0;
        w_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    w_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                data_sel = 1'b1;
                stage_en = in_valid;
                if (in_valid && (in_cnt_q == IN_LAST)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                stage_en = 1'b1;
                if (w_out_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Input, fill and output counters; all frozen while stage_en is low.
    always_comb begin
        in_cnt_d   = in_cnt_q;
        fill_cnt_d = fill_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (w_clr) begin
            in_cnt_d   = '0;
            fill_cnt_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (in_ready && in_valid) begin
                in_cnt_d = in_cnt_q + 1'b1;
            end
            if (stage_en && (fill_cnt_q != FILL_MAX)) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
            if (out_valid) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= '0;
            fill_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // Output sample markers, aligned with the last stage's data.
    always_comb begin
        out_valid = stage_en && w_out_ok;
        out_last  = out_valid && (out_cnt_q == OUT_LAST);
`ifdef FFT_SEQ_DIGITREV_EN
        out_index = AW'(digit_rev4(32'(out_cnt_q[AW-1:0]), AW / 2));
`else
        out_index = out_cnt_q[AW-1:0];
`endif
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            fft_b4_tw_gen #(
                .STAGES    (STAGES),
                .STAGE_LAT (STAGE_LAT),
                .AW        (AW),
                .S         (s),
                .FW        (FW)
            ) u_tw_gen (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_clr),
                .en        (stage_en),
                .fill_cnt  (fill_cnt_q),
                .tw_addr   (tw_addr[s*AW +: AW])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fft_b4_seq_ctrl.sv
// ============================================================================
// Module   : tb_fft_b4_seq_ctrl
// Purpose  : Scoreboard bench for fft_b4_seq_ctrl (STAGES=3, STAGE_LAT=4).
//            Expected per-enabled-cycle responses come from an arithmetic
//            reference model; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_b4_seq_ctrl;

    localparam int STAGES    = 3;
    localparam int STAGE_LAT = 4;
    localparam int AW        = 6;
    localparam int N         = 64;
    localparam int PIPE_LAT  = 12;
    localparam int TW        = STAGES * AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          stage_en;
    logic          data_sel;
    logic [TW-1:0] tw_addr;
    logic          out_valid;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    fft_b4_seq_ctrl #(
        .STAGES    (STAGES),
        .STAGE_LAT (STAGE_LAT),
        .AW        (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stage_en   (stage_en),
        .data_sel   (data_sel),
        .tw_addr    (tw_addr),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tw;
        logic          ov;
        logic [AW-1:0] idx;
        logic          last;
        logic          dsel;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic void chk(input string name, input longint unsigned act,
                                input longint unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Twiddle address from the arithmetic definition.
    function automatic int ref_tw(input int c, input int s);
        int p;
        int m;
        p = c % 4;
        m = (c / 4) % (N / (4 ** (s + 1)));
        return (p * m * (4 ** s)) % N;
    endfunction

    // Output index for output number o.
    function automatic int ref_idx(input int o);
`ifdef FFT_SEQ_DIGITREV_EN
        int r;
        int x;
        r = 0;
        x = o;
        for (int d = 0; d < STAGES; d++) begin
            r = r * 4 + (x % 4);
            x = x / 4;
        end
        return r;
`else
        return o;
`endif
    endfunction

    // Expected observation on the k-th enabled cycle of a frame.
    function automatic rec_t ref_rec(input int k);
        rec_t r;
        int   c;
        int   o;
        r = '0;
        for (int s = 0; s < STAGES; s++) begin
            c = (k > s * STAGE_LAT) ? ((k - s * STAGE_LAT) % N) : 0;
            r.tw[s*AW +: AW] = AW'(ref_tw(c, s));
        end
        o      = k - PIPE_LAT;
        r.ov   = (o >= 0);
        r.idx  = (o >= 0) ? AW'(ref_idx(o)) : '0;
        r.last = (o == N - 1);
        r.dsel = (k < N);
        return r;
    endfunction

    // Monitor: every enabled cycle consumes one expected record; stalled
    // cycles must hold the state the next enabled cycle will show.
    always @(negedge clk) begin
        if (!rst) begin
            if (stage_en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_stage_en: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("tw_addr",   tw_addr,   mon_r.tw);
                    chk("out_valid", out_valid, mon_r.ov);
                    chk("out_index", out_index, mon_r.idx);
                    chk("out_last",  out_last,  mon_r.last);
                    chk("data_sel",  data_sel,  mon_r.dsel);
                    chk("in_ready",  in_ready,  mon_r.dsel);
                end
            end else if (busy && exp_q.size() > 0) begin
                chk("stall_out_valid", out_valid, 0);
                chk("stall_out_last",  out_last,  0);
                chk("stall_tw_addr",   tw_addr,   exp_q[0].tw);
                chk("stall_out_index", out_index, exp_q[0].idx);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},   in_ready,   0);
        chk({tag, "_stage_en"},   stage_en,   0);
        chk({tag, "_data_sel"},   data_sel,   0);
        chk({tag, "_tw_addr"},    tw_addr,    0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_index"},  out_index,  0);
        chk({tag, "_out_last"},   out_last,   0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // One frame: stall_at>=0 drops in_valid for 5 cycles at that input
    // count; rnd adds random stalls; abort resets the DUT mid-FLUSH.
    task automatic run_frame(input int stall_at, input bit rnd, input bit abort);
        int acc;
        int stalls_left;
        int guard;
        int cycles;
        bit v;
        for (int k = 0; k < N + PIPE_LAT; k++) exp_q.push_back(ref_rec(k));
        start = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        acc         = 0;
        stalls_left = 5;
        guard       = 0;
        while (acc < N && guard < 2000) begin
            v = 1'b1;
            if (acc == stall_at && stalls_left > 0) begin
                v = 1'b0;
                stalls_left--;
            end else if (rnd && $urandom_range(0, 5) == 0) begin
                v = 1'b0;
            end
            in_valid = v;
            start    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            chk("load_in_ready", in_ready, 1);
            chk("load_busy",     busy,     1);
            @(posedge clk); #1;
            if (v) acc++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort) begin
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b1;
            exp_q.delete();
            @(negedge clk);
            check_all_zero("abort");
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("abort_no_frame_done", frame_done, 0);
                chk("abort_idle_busy",     busy,       0);
            end
        end else begin
            cycles = 0;
            while (1) begin
                @(negedge clk);
                if (frame_done) break;
                cycles++;
                if (cycles > 200) break;
            end
            chk("done_latency",       cycles,       PIPE_LAT);
            chk("scoreboard_drained", exp_q.size(), 0);
            exp_q.delete();
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done_ignored", busy,       0);
            chk("frame_done_one_cycle",  frame_done, 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(-1, 1'b0, 1'b0);
        run_frame(30, 1'b0, 1'b0);
        run_frame(20, 1'b0, 1'b1);
        run_frame(-1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(-1, 1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
